rx_sb_multistep_responder: RTL
==============================

Name: rx_sb_multistep_responder

Overview:
- Parametrised RX-side sideband responder for LTSM training states (SBINIT, MBINIT sub-steps and similar).
- Waits for a sequence of NUM_STEPS partner request messages. Answers each one with its paired response over the shared SB encoder and arbitrates bus access against the TX-side sequencer.
- Signals sequence completion to the LTSM, or a timeout if the partner stalls.
- Replaces the single-request SBINIT RX responder: adds step count, message-qualified decode, and a timeout.

Parameters:
- SB_MSG_WIDTH, 4, width of encoded/decoded SB message codes.
- NUM_STEPS, 2, number of request/response pairs in the sequence (1..8).
- REQ_BASE, 1, code of step-0 request. Step k request = REQ_BASE+2k; step k response = REQ_BASE+2k+1. REQ_BASE+2*NUM_STEPS-1 must be < 2^SB_MSG_WIDTH.
- TIMEOUT_CYCLES, 8000, cycles allowed from leaving IDLE to DONE; 0 disables the timeout.

Ports:
- i_clk, input, 1, clock.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_en, input, 1, enable from LTSM; low returns the block to IDLE.
- i_msg_valid, input, 1, one-cycle strobe: i_decoded_SB_msg holds a newly received message.
- i_decoded_SB_msg, input, SB_MSG_WIDTH, decoded partner message.
- i_SB_Busy, input, 1, SB is serialising a message.
- i_falling_edge_busy, input, 1, one-cycle pulse when SB finishes sending.
- i_tx_valid, input, 1, TX sequencer currently drives the SB request.
- o_encoded_SB_msg_rx, output, SB_MSG_WIDTH, response code to SB encoder.
- o_valid_rx, output, 1, response request to SB.
- o_step, output, 3, index of the step currently awaited or being answered.
- o_seq_done, output, 1, all steps answered.
- o_timeout, output, 1, sequence timed out.

Behaviour:
- Reset values: every output and internal register is 0; state is IDLE.
- States and transitions:
  - IDLE → WAIT_REQ when i_en=1.
  - WAIT_REQ → SEND_RESP on i_msg_valid=1 and i_decoded_SB_msg = REQ_BASE+2*o_step. Any other message, or a message without i_msg_valid, is ignored.
  - SEND_RESP → WAIT_REQ with o_step+1 on fe_valid when o_step < NUM_STEPS-1.
  - SEND_RESP → DONE on fe_valid when o_step = NUM_STEPS-1.
  - DONE and ERROR hold until i_en=0.
  - Any state with i_en=0 → IDLE at the next edge. On that same edge all outputs, the pending flag, the step counter and the timeout counter clear to 0. This holds mid-handshake; a valid that was up drops immediately.
- fe_valid definition:
  - prev_valid is o_valid_rx registered.
  - fe_valid = prev_valid & ~o_valid_rx.
  - The state advances on the edge after the cycle in which fe_valid is high.
- Response issue:
  - On the WAIT_REQ→SEND_RESP edge, o_encoded_SB_msg_rx ← REQ_BASE+2*o_step+1.
  - On that same edge, o_valid_rx ← 1 if i_SB_Busy=0 and i_tx_valid=0; otherwise pending ← 1.
  - While pending=1, o_valid_rx ← 1 on the first edge where i_SB_Busy=0 and i_tx_valid=0; pending clears once o_valid_rx=1.
  - o_encoded_SB_msg_rx holds its value until the next response or IDLE.
- Valid drop: i_falling_edge_busy=1 forces o_valid_rx ← 0. It takes priority over a simultaneous set.
- o_seq_done ← 1 on the SEND_RESP→DONE edge and holds in DONE.
- Timeout:
  - Counter increments each cycle in WAIT_REQ or SEND_RESP and holds in DONE/ERROR.
  - When the counter = TIMEOUT_CYCLES-1 and the next state is not DONE, the block enters ERROR and o_timeout ← 1, with o_valid_rx and pending forced to 0.
  - If completion and timeout fall on the same edge, DONE wins.
  - TIMEOUT_CYCLES=0: the counter is frozen and ERROR is unreachable.
- Request during SEND_RESP is ignored; no queuing.
- o_step never exceeds NUM_STEPS-1.

Test Plan (NUM_STEPS=2, REQ_BASE=1, SB_MSG_WIDTH=4, TIMEOUT_CYCLES=200 unless noted):
- Nominal: i_en=1; strobe msg 1; pulse i_falling_edge_busy 3 cycles later; strobe msg 3; pulse busy edge → responses 2 then 4, o_valid_rx rises the edge after each strobe, o_step goes 0→1, o_seq_done=1 and stays, o_timeout=0.
- Arbitration: i_tx_valid=1 when msg 1 arrives → o_valid_rx stays 0, msg=2. Drop i_tx_valid → o_valid_rx=1 on the next edge.
- Wrong/out-of-order: in WAIT_REQ at step 0, strobe msg 3, then msg 1 without i_msg_valid → no state change and o_valid_rx=0. A valid strobe of msg 1 then gets response 2.
- Timeout: i_en=1, no messages → o_timeout=1 exactly 200 cycles after leaving IDLE, o_valid_rx=0. Drop i_en → all outputs 0 next edge.
- Reset/disable mid-op: o_valid_rx=1 at step 1, then i_en=0 → o_valid_rx, o_step, msg all 0 next edge. Async i_rst_n low mid-cycle clears everything immediately.
- Simultaneous: i_falling_edge_busy coincides with the pending-set condition → o_valid_rx=0 that edge. With TIMEOUT_CYCLES=0 and no messages for 10000 cycles → o_timeout stays 0.

Source files
------------

// File: rtl/rx_sb_multistep_responder.sv
// ---------------------------------------------------------------------------
// rx_sb_multistep_responder
//
// RX-side sideband responder for multi-step LTSM training states. It waits
// for NUM_STEPS partner requests in order (step k request = REQ_BASE+2k) and
// answers each one with its paired response (REQ_BASE+2k+1) over the shared
// SB encoder. The response waits while the SB is busy or the TX sequencer owns
// the bus. Completion is flagged on o_seq_done. A stalled partner raises
// o_timeout after TIMEOUT_CYCLES cycles; TIMEOUT_CYCLES=0 disables the timeout.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_en                  enable from LTSM; low returns the block to IDLE
//   i_msg_valid           strobe: i_decoded_SB_msg holds a new message
//   i_decoded_SB_msg      decoded partner message code
//   i_SB_Busy             SB is serialising a message
//   i_falling_edge_busy   pulse when SB finishes sending
//   i_tx_valid            TX sequencer currently drives the SB request
//   o_encoded_SB_msg_rx   response code to the SB encoder
//   o_valid_rx            response request to the SB
//   o_step                step currently awaited or being answered
//   o_seq_done            all steps answered
//   o_timeout             sequence timed out
// ---------------------------------------------------------------------------
module rx_sb_multistep_responder #(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int NUM_STEPS      = 2,
    parameter int REQ_BASE       = 1,
    parameter int TIMEOUT_CYCLES = 8000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    input  logic                    i_SB_Busy,
    input  logic                    i_falling_edge_busy,
    input  logic                    i_tx_valid,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
    output logic                    o_valid_rx,
    output logic [2:0]              o_step,
    output logic                    o_seq_done,
    output logic                    o_timeout
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_REQ  = 3'd1;
    localparam logic [2:0] ST_SEND_RESP = 3'd2;
    localparam logic [2:0] ST_DONE      = 3'd3;
    localparam logic [2:0] ST_ERROR     = 3'd4;

    localparam logic [2:0]  LAST_STEP = 3'(NUM_STEPS - 1);
    localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]              state_r;
    logic [2:0]              state_nxt_s;
    logic [2:0]              step_r;
    logic [SB_MSG_WIDTH-1:0] msg_r;
    logic                    valid_r;
    logic                    prev_valid_r;
    logic                    pending_r;
    logic                    done_r;
    logic                    timeout_r;
    logic [31:0]             cnt_r;

    logic [SB_MSG_WIDTH-1:0] req_code_s;
    logic [SB_MSG_WIDTH-1:0] resp_code_s;
    logic                    req_hit_s;
    logic                    bus_free_s;
    logic                    fe_valid_s;
    logic                    active_s;
    logic                    timeout_hit_s;

    // Expected request/response codes for the current step and bus qualifiers.
    always_comb begin
        req_code_s  = SB_MSG_WIDTH'(REQ_BASE) + SB_MSG_WIDTH'({step_r, 1'b0});
        resp_code_s = req_code_s + SB_MSG_WIDTH'(1);
        req_hit_s   = i_msg_valid && (i_decoded_SB_msg == req_code_s);
        bus_free_s  = ~i_SB_Busy & ~i_tx_valid;
        // The response has left the SB once our own valid has dropped.
        fe_valid_s  = prev_valid_r & ~valid_r;
        active_s    = (state_r == ST_WAIT_REQ) || (state_r == ST_SEND_RESP);
    end

    // Next-state decode of the sequencing FSM (timeout handled separately).
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_en) state_nxt_s = ST_WAIT_REQ;
                else      state_nxt_s = ST_IDLE;
            end
            ST_WAIT_REQ: begin
                if (req_hit_s) state_nxt_s = ST_SEND_RESP;
                else           state_nxt_s = ST_WAIT_REQ;
            end
            ST_SEND_RESP: begin
                if (fe_valid_s && (step_r == LAST_STEP)) state_nxt_s = ST_DONE;
                else if (fe_valid_s)                     state_nxt_s = ST_WAIT_REQ;
                else                                     state_nxt_s = ST_SEND_RESP;
            end
            ST_DONE:  state_nxt_s = ST_DONE;
            ST_ERROR: state_nxt_s = ST_ERROR;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Timeout fires on the last allowed cycle unless completion lands on the same edge.
    always_comb begin
        if (TO_EN && active_s && (cnt_r == TO_LAST) && (state_nxt_s != ST_DONE)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Sequencing state, step counter, response handshake and timeout counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            step_r       <= 3'd0;
            msg_r        <= '0;
            valid_r      <= 1'b0;
            prev_valid_r <= 1'b0;
            pending_r    <= 1'b0;
            done_r       <= 1'b0;
            timeout_r    <= 1'b0;
            cnt_r        <= 32'd0;
        end else if (!i_en) begin
            state_r      <= ST_IDLE;
            step_r       <= 3'd0;
            msg_r        <= '0;
            valid_r      <= 1'b0;
            prev_valid_r <= 1'b0;
            pending_r    <= 1'b0;
            done_r       <= 1'b0;
            timeout_r    <= 1'b0;
            cnt_r        <= 32'd0;
        end else if (timeout_hit_s) begin
            state_r      <= ST_ERROR;
            timeout_r    <= 1'b1;
            valid_r      <= 1'b0;
            pending_r    <= 1'b0;
            prev_valid_r <= valid_r;
        end else begin
            state_r      <= state_nxt_s;
            prev_valid_r <= valid_r;

            if (TO_EN && active_s) begin
                cnt_r <= cnt_r + 32'd1;
            end else begin
                cnt_r <= cnt_r;
            end

            if ((state_r == ST_SEND_RESP) && fe_valid_s && (step_r != LAST_STEP)) begin
                step_r <= step_r + 3'd1;
            end else begin
                step_r <= step_r;
            end

            if ((state_r == ST_SEND_RESP) && (state_nxt_s == ST_DONE)) begin
                done_r <= 1'b1;
            end else begin
                done_r <= done_r;
            end

            // A busy falling edge always wins over a simultaneous valid set;
            // a blocked set stays pending and retries on a later edge.
            if ((state_r == ST_WAIT_REQ) && req_hit_s) begin
                msg_r <= resp_code_s;
                if (bus_free_s && !i_falling_edge_busy) begin
                    valid_r   <= 1'b1;
                    pending_r <= 1'b0;
                end else begin
                    valid_r   <= 1'b0;
                    pending_r <= 1'b1;
                end
            end else if (pending_r) begin
                if (i_falling_edge_busy) begin
                    valid_r <= 1'b0;
                end else if (bus_free_s) begin
                    valid_r   <= 1'b1;
                    pending_r <= 1'b0;
                end else begin
                    valid_r <= valid_r;
                end
            end else if (i_falling_edge_busy) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign o_encoded_SB_msg_rx = msg_r;
    assign o_valid_rx          = valid_r;
    assign o_step              = step_r;
    assign o_seq_done          = done_r;
    assign o_timeout           = timeout_r;

endmodule
